// File: rtl/decode_writeback_if.sv
// Decode/write-back bus: fetch/execute/memory results in, register reads,
// write destinations and processor status out.
interface decode_writeback_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        inst_valid;
  logic        imem_er;
  logic        dmem_er;
  logic        hlt_er;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [2:0]  stat;

  // Upstream pipeline side: drives instruction fields and results.
  modport master (
    output icode, rA, rB, cnd, valE, valM, inst_valid, imem_er, dmem_er, hlt_er,
    input  valA, valB, dstE, dstM, stat
  );

  // Decode/write-back stage side.
  modport slave (
    input  icode, rA, rB, cnd, valE, valM, inst_valid, imem_er, dmem_er, hlt_er,
    output valA, valB, dstE, dstM, stat
  );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 decode + write-back stage: register ID derivation, 15 x 64-bit
// register file with combinational reads, and sticky processor status.
module decode_writeback #(
  parameter logic [63:0] STACK_INIT = 64'd0
) (
  input logic               clk,
  input logic               rst,
  decode_writeback_if.slave bus
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [2:0]  stat_reg;
  logic [2:0]  stat_next;
  logic        commit_en;
  logic        we_e;
  logic        we_m;
  logic [63:0] rf [16];

  // Source A: rA for register-operand forms, %rsp for stack readers.
  always_comb begin
    src_a = RNONE;
    case (bus.icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = bus.rA;
      I_RET, I_POPQ:                      src_a = RRSP;
      default:                            src_a = RNONE;
    endcase
  end

  // Source B: rB for base/operand forms, %rsp for all stack operations.
  always_comb begin
    src_b = RNONE;
    case (bus.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:         src_b = bus.rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    src_b = RRSP;
      default:                           src_b = RNONE;
    endcase
  end

  // E destination: cmovXX only writes when the condition holds.
  always_comb begin
    dst_e = RNONE;
    case (bus.icode)
      I_RRMOVQ:                          dst_e = (bus.cnd === 1'b1) ? bus.rB : RNONE;
      I_IRMOVQ, I_OPQ:                   dst_e = bus.rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    dst_e = RRSP;
      default:                           dst_e = RNONE;
    endcase
  end

  // M destination: loads and pops deliver memory data into rA.
  always_comb begin
    dst_m = RNONE;
    case (bus.icode)
      I_MRMOVQ, I_POPQ: dst_m = bus.rA;
      default:          dst_m = RNONE;
    endcase
  end

  // Status register: holds the sticky processor state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reg <= S_AOK;
    end else begin
      stat_reg <= stat_next;
    end
  end

  // Status next-state: address faults outrank invalid instruction, which
  // outranks halt; any non-AOK state is terminal until reset.
  always_comb begin
    stat_next = stat_reg;
    if (stat_reg == S_AOK) begin
      if (bus.imem_er || bus.dmem_er) begin
        stat_next = S_ADR;
      end else if (!bus.inst_valid) begin
        stat_next = S_INS;
      end else if (bus.hlt_er) begin
        stat_next = S_HLT;
      end
    end
  end

  // Status outputs: the instruction commits only from AOK with no fault
  // flagged on the same edge.
  always_comb begin
    bus.stat  = stat_reg;
    commit_en = (stat_reg == S_AOK) && !bus.imem_er && !bus.dmem_er &&
                !bus.hlt_er && bus.inst_valid;
  end

  assign we_e = commit_en && (dst_e != RNONE);
  assign we_m = commit_en && (dst_m != RNONE);

  // Register file: one flop bank per architectural register. ID 15 is the
  // "none" slot and always reads zero.
  assign rf[15] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi = gi + 1) begin : gen_reg
      localparam logic [3:0]  IDX       = 4'(gi);
      localparam logic [63:0] RESET_VAL = (gi == 4) ? STACK_INIT : 64'd0;

      logic        hit_e;
      logic        hit_m;
      logic [63:0] r_reg;

      assign hit_e = we_e && (dst_e == IDX);
      assign hit_m = we_m && (dst_m == IDX);

      // Commit write-back; valM takes priority when both ports target this
      // register (popq %rsp).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_reg <= RESET_VAL;
        end else if (hit_m) begin
          r_reg <= bus.valM;
        end else if (hit_e) begin
          r_reg <= bus.valE;
        end
      end

      assign rf[gi] = r_reg;
    end
  endgenerate

  // Read ports and destination IDs are purely combinational.
  assign bus.valA = rf[src_a];
  assign bus.valB = rf[src_b];
  assign bus.dstE = dst_e;
  assign bus.dstM = dst_m;

endmodule

// File: doc/decode_writeback.md
# decode_writeback

Combined decode and write-back stage for the sequential Y86-64 core, directly downstream of `fetch`. It holds the 15-entry × 64-bit program register file and derives source and destination register IDs from `icode`, `rA` and `rB`. It supplies `valA` and `valB` to execute, and commits `valE` and `valM` at the clock edge that ends the instruction. It also keeps the sticky processor status, which freezes architectural state after halt or a fault.

## Interface
Parameters:
- `STACK_INIT`, default 64'd0: reset value of %rsp (reg 4).

Ports:
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `icode`  input  4: instruction code from fetch.
- `rA`  input  4: register specifier A from fetch.
- `rB`  input  4: register specifier B from fetch.
- `cnd`  input  1: condition result from execute; gates the cmovXX write.
- `valE`  input  64: ALU result from execute.
- `valM`  input  64: data-memory read value.
- `inst_valid`  input  1: 0 means invalid instruction.
- `imem_er`  input  1: instruction address fault.
- `dmem_er`  input  1: data address fault.
- `hlt_er`  input  1: halt fetched.
- `valA`  output  64: register read port A (combinational).
- `valB`  output  64: register read port B (combinational).
- `dstE`  output  4: E-write destination (15 = none).
- `dstM`  output  4: M-write destination (15 = none).
- `stat`  output  3: 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS (registered).

## Operation
ID derivation is combinational; register 15 means "none".
- srcA:
  - `rA` for icode 2, 4, 6, 10.
  - 4 (%rsp) for icode 9, 11.
  - Otherwise 15.
- srcB:
  - `rB` for icode 4, 5, 6.
  - 4 for icode 8, 9, 10, 11.
  - Otherwise 15.
- dstE:
  - `rB` for icode 3 and 6.
  - `rB` for icode 2 only when `cnd`=1, otherwise 15.
  - 4 for icode 8, 9, 10, 11.
  - Otherwise 15.
- dstM: `rA` for icode 5 and 11; otherwise 15.
- `rA` and `rB` are ignored for icodes that do not use them; their stale values must not affect the outputs.

Reads:
- `valA` = regs[srcA] and `valB` = regs[srcB].
- Reading ID 15 returns 64'd0.
- Reads show contents from before this cycle's write. There is no internal bypass.

Writes, at the rising edge:
- Each write is enabled only when `stat`=AOK and none of `imem_er`, `dmem_er`, `hlt_er` is set and `inst_valid`=1.
- regs[dstE] ← `valE` when dstE≠15.
- regs[dstM] ← `valM` when dstM≠15.
- If dstE==dstM≠15 (popq %rsp), `valM` wins.

Status, at the rising edge while `stat`=AOK:
- ADR if `imem_er` or `dmem_er`.
- Else INS if `inst_valid`=0.
- Else HLT if `hlt_er`.
- Else stays AOK.
- Once non-AOK, `stat` holds until `rst` and the file is frozen. Reads continue to work.

## Timing
- Reset:
  - Asserting `rst` immediately clears all regs to 0, except reg 4 = `STACK_INIT`, and sets `stat` to AOK (1).
  - `valA`, `valB`, `dstE`, `dstM` follow combinationally from the inputs and the reset contents.
- Reset asserted mid-cycle discards any pending write. The first edge after `rst` deasserts performs a normal write.
- Latency:
  - ID and read paths have 0 cycles of latency.
  - A write is visible on `valA`/`valB` after the edge that commits it, i.e. to the next instruction.
- Error inputs and the write they suppress are sampled at the same edge. The faulting instruction commits nothing.
- Inputs with X or undefined icode (12–15) produce IDs of 15. Status is flagged INS via `inst_valid`.

## Test plan
- Reset, then read: `rst` pulse with `STACK_INIT`=64'h100, icode=9 → `valA`=`valB`=64'h100; icode=6 with rA=0, rB=3 → `valA`=`valB`=0; `stat`=1.
- irmovq then OPq: icode=3, rB=0, `valE`=4, edge; then icode=6, rA=0, rB=3 → `valA`=4, `dstE`=3. With `valE`=10, after the edge regs[3]=10.
- cmov gating: icode=2, rA=0, rB=2, `cnd`=0, `valE`=7, edge → regs[2] unchanged, `dstE`=15. With `cnd`=1 → regs[2]=7.
- popq %rsp conflict: icode=11, rA=4, `valE`=64'h108, `valM`=64'h55, edge → regs[4]=64'h55.
- Halt freeze: `hlt_er`=1 with icode=0, edge → `stat`=2. A subsequent icode=3, rB=1, `valE`=9 edge → regs[1] stays 0 and `stat` stays 2 until `rst`.
- Fault priority: `dmem_er`=1 and `inst_valid`=0 on the same edge with icode=5, rA=1 → `stat`=3 and regs[1] not written.
